// File: rtl/cdc_hs_arbiter.sv
// cdc_hs_arbiter
//   Source-domain controller that shares one 4-phase req/ack crossing among
//   NREQ local requesters. A round-robin winner's payload is captured into a
//   register and held for the whole handshake. The returning acknowledge is
//   synchronized with a flop chain before use.
//
// Ports
//   clk, rst_n       source clock, asynchronous active-low reset
//   req_vld[NREQ]    per-requester request, held until its req_gnt pulse
//   req_data         NREQ payloads, requester i at [i*DW +: DW]
//   req_gnt[NREQ]    one-cycle pulse: payload captured
//   req_done[NREQ]   one-cycle pulse: that requester's handshake completed
//   xfer_req         registered crossing request
//   xfer_data        registered payload, stable during the handshake
//   xfer_id          registered index of the granted requester
//   xfer_ack_async   acknowledge from the destination domain (asynchronous)
//   busy             high whenever the controller is not idle
//   timeout_err      sticky flag: request held high for TO_CYCLES cycles
module cdc_hs_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TO_CYCLES   = 64,
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_vld,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_gnt,
  output logic [NREQ-1:0]    req_done,
  output logic               xfer_req,
  output logic [DW-1:0]      xfer_data,
  output logic [IW-1:0]      xfer_id,
  input  logic               xfer_ack_async,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned SW = $clog2(SYNC_STAGES + 1);
  localparam int unsigned TW = $clog2(TO_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [SW-1:0]          settle_cnt;
  logic                   settle_done;
  logic [TW-1:0]          to_cnt;
  logic [IW-1:0]          ptr, ptr_next;
  logic [IW-1:0]          winner;
  logic                   win_found;
  logic [DW-1:0]          win_data;
  int unsigned            rr_idx;
  logic                   grant_now;
  logic                   xfer_req_next;
  logic [NREQ-1:0]        gnt_next, done_next;

  // Acknowledge synchronizer; only the last stage is used by control logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], xfer_ack_async};
  end
  assign ack_s = ack_sync[SYNC_STAGES-1];

  // Settle counter: lets the synchronizer flush after reset before granting.
  assign settle_done = (settle_cnt == SW'(SYNC_STAGES));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            settle_cnt <= '0;
    else if (!settle_done) settle_cnt <= settle_cnt + SW'(1);
  end

  // Round-robin search: first set bit at or above ptr, wrapping around.
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    rr_idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rr_idx = 32'(ptr) + k;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      if (!win_found && req_vld[IW'(rr_idx)]) begin
        winner    = IW'(rr_idx);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      if (winner == IW'(i)) win_data = req_data[i*DW +: DW];
  end

  assign ptr_next  = (32'(winner) == NREQ - 1) ? '0 : winner + IW'(1);
  assign grant_now = (state == IDLE) && settle_done && !ack_s && win_found;
  assign busy      = (state != IDLE);

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      req_gnt     <= '0;
      req_done    <= '0;
      xfer_req    <= 1'b0;
      xfer_data   <= '0;
      xfer_id     <= '0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_next;
      req_gnt  <= gnt_next;
      req_done <= done_next;
      xfer_req <= xfer_req_next;
      if (grant_now) begin
        xfer_data <= win_data;
        xfer_id   <= winner;
        ptr       <= ptr_next;
      end
      if (state == REQ_HI) begin
        if (ack_s) begin
          to_cnt <= '0;
        end else if (to_cnt != TW'(TO_CYCLES)) begin
          to_cnt <= to_cnt + TW'(1);
          if (to_cnt == TW'(TO_CYCLES - 1)) timeout_err <= 1'b1;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_now) state_next = REQ_HI;
      REQ_HI:  if (ack_s)     state_next = REQ_LO;
      REQ_LO:  if (!ack_s)    state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    gnt_next      = '0;
    done_next     = '0;
    xfer_req_next = xfer_req;
    case (state)
      IDLE: begin
        if (grant_now) begin
          gnt_next[winner] = 1'b1;
          xfer_req_next    = 1'b1;
        end
      end
      REQ_HI:  if (ack_s)  xfer_req_next = 1'b0;
      REQ_LO:  if (!ack_s) done_next[xfer_id] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
module tb_cdc_hs_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int SS   = 2;
  localparam int TO   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_vld;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_gnt, req_done;
  logic              xfer_req;
  logic [DW-1:0]     xfer_data;
  logic [1:0]        xfer_id;
  logic              ack;
  logic              busy, timeout_err;

  int checks, failures;
  int ptr_m;

  cdc_hs_arbiter #(.NREQ(NREQ), .DW(DW), .SYNC_STAGES(SS), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_data(req_data),
    .req_gnt(req_gnt), .req_done(req_done), .xfer_req(xfer_req),
    .xfer_data(xfer_data), .xfer_id(xfer_id), .xfer_ack_async(ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first requesting index at or after p, circularly.
  function automatic int pick(input int p, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'($urandom);
  endtask

  // One complete handshake driven from the far side with given ack delays.
  task automatic do_xfer(input logic [NREQ-1:0] vld, input int gnt_lat,
                         input int rise_dly, input int fall_dly, output int won);
    int w, n;
    logic [DW-1:0] d;
    req_vld = vld;
    w = pick(ptr_m, vld);
    d = req_data[w*DW +: DW];
    n = 0;
    do begin step(); n++; end while (req_gnt == '0 && n < 12);
    chk("gnt_latency", n, gnt_lat);
    chk("gnt_onehot", req_gnt, 1 << w);
    chk("xfer_req_up", xfer_req, 1);
    chk("xfer_id", xfer_id, w);
    chk("xfer_data", xfer_data, d);
    chk("busy_hi", busy, 1);
    ptr_m = (w + 1) % NREQ;
    won = w;
    rand_data();
    for (int i = 0; i < rise_dly; i++) begin
      step();
      chk("gnt_pulse_once", req_gnt, 0);
      chk("xfer_req_hold", xfer_req, 1);
      chk("data_hold_hi", xfer_data, d);
    end
    ack = 1'b1;
    n = 0;
    do begin
      step(); n++;
      chk("data_hold_ack", xfer_data, d);
      chk("id_hold_ack", xfer_id, w);
      chk("no_gnt_ack", req_gnt, 0);
    end while (xfer_req === 1'b1 && n < 12);
    chk("ack_rise_to_req_fall", n, SS + 1);
    for (int i = 0; i < fall_dly; i++) begin
      step();
      chk("req_lo_hold", xfer_req, 0);
      chk("no_early_done", req_done, 0);
      chk("busy_req_lo", busy, 1);
    end
    ack = 1'b0;
    n = 0;
    do begin
      step(); n++;
      chk("data_hold_lo", xfer_data, d);
      chk("no_gnt_lo", req_gnt, 0);
    end while (req_done == '0 && n < 12);
    chk("ack_fall_to_done", n, SS + 1);
    chk("done_onehot", req_done, 1 << w);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int won, w, n;
    logic [NREQ-1:0] v;
    checks = 0; failures = 0; ptr_m = 0;
    rst_n = 1'b0; ack = 1'b0; req_vld = '0; req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", req_gnt, 0);
    chk("rst_done", req_done, 0);
    chk("rst_xfer_req", xfer_req, 0);
    chk("rst_xfer_data", xfer_data, 0);
    chk("rst_xfer_id", xfer_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);

    // Release reset with a pending request: grant waits for the settle period.
    rand_data();
    rst_n = 1'b1;
    do_xfer(4'b0001, SS + 1, 1, 0, won);
    chk("settle_winner", won, 0);

    // Single requester with a fixed payload.
    rand_data();
    req_data[2*DW +: DW] = 8'hA5;
    do_xfer(4'b0100, 1, 3, 1, won);
    chk("single_winner", won, 2);
    req_vld = '0;
    step();
    chk("done_single_pulse", req_done, 0);

    // Bring pointer to 0, then all requesters held continuously.
    rand_data();
    do_xfer(4'b1000, 1, 0, 0, won);
    for (int i = 0; i < 5; i++) begin
      rand_data();
      do_xfer(4'b1111, 1, $urandom_range(0, 3), $urandom_range(0, 3), won);
      chk("rr_order", won, i % NREQ);
    end
    req_vld = '0;
    step();

    // Pointer check: after a grant to 1, requesters 0 and 3 -> 3 then 0.
    rand_data();
    do_xfer(4'b0010, 1, 0, 0, won);
    chk("ptr_grant1", won, 1);
    rand_data();
    do_xfer(4'b1001, 1, 1, 1, won);
    chk("ptr_first3", won, 3);
    rand_data();
    do_xfer(4'b1001, 1, 1, 1, won);
    chk("ptr_then0", won, 0);
    req_vld = '0;
    step();

    // Randomized transactions against the reference arbitration model.
    for (int t = 0; t < 16; t++) begin
      rand_data();
      v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      do_xfer(v, 1, $urandom_range(0, 3), $urandom_range(0, 3), won);
      req_vld = '0;
      repeat ($urandom_range(1, 2)) begin
        step();
        chk("idle_no_gnt", req_gnt, 0);
      end
    end

    // Stale ack in IDLE; a withdrawn request never gets granted.
    ack = 1'b1;
    repeat (3) step();
    req_vld = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stale_no_gnt_a", req_gnt, 0);
      chk("stale_idle", busy, 0);
    end
    req_vld = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stale_no_gnt_b", req_gnt, 0);
    end
    rand_data();
    ack = 1'b0;
    do_xfer(4'b0001, SS + 1, 1, 1, won);
    chk("stale_winner", won, 0);
    chk("withdraw_no_err", timeout_err, 0);
    req_vld = '0;
    step();

    // Timeout: ack withheld; flag sticks, no abort, other requests ignored.
    rand_data();
    req_vld = 4'b0100;
    w = pick(ptr_m, 4'b0100);
    step();
    chk("to_gnt", req_gnt, 1 << w);
    ptr_m = (w + 1) % NREQ;
    req_vld = 4'b1011;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("to_no_gnt", req_gnt, 0);
      chk("to_req_hold", xfer_req, 1);
      if (i == 14) chk("to_not_yet", timeout_err, 0);
      if (i >= 16) chk("to_flag", timeout_err, 1);
    end
    ack = 1'b1;
    n = 0;
    do begin step(); n++; end while (xfer_req === 1'b1 && n < 12);
    chk("to_ack_rise", n, SS + 1);
    ack = 1'b0;
    n = 0;
    do begin step(); n++; end while (req_done == '0 && n < 12);
    chk("to_ack_fall", n, SS + 1);
    chk("to_done", req_done, 1 << w);
    req_vld = '0;
    step();
    chk("to_sticky", timeout_err, 1);
    chk("to_gnt_after", req_gnt, 0);

    // Reset mid-REQ_HI with the far side holding ack high.
    rand_data();
    req_vld = 4'b0001;
    step();
    chk("rstmid_gnt", req_gnt, 1 << pick(ptr_m, 4'b0001));
    req_vld = '0;
    step();
    ack = 1'b1;
    step();
    chk("rstmid_in_req_hi", xfer_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_xfer_req", xfer_req, 0);
    chk("rstmid_xfer_data", xfer_data, 0);
    chk("rstmid_xfer_id", xfer_id, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_timeout", timeout_err, 0);
    chk("rstmid_gnt0", req_gnt, 0);
    chk("rstmid_done", req_done, 0);
    repeat (2) step();
    rst_n = 1'b1;
    ptr_m = 0;
    req_vld = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rstmid_ack_block", req_gnt, 0);
    end
    rand_data();
    ack = 1'b0;
    do_xfer(4'b0001, SS + 1, 0, 0, won);
    chk("rstmid_winner", won, 0);
    req_vld = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
